// File: rtl/timer_pkg.sv
// Shared FSM encodings, BCD limits and the load-saturation helper for countdown_timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0] MAX_TENS    = 4'd5;
  localparam logic [3:0] MAX_UNITS   = 4'd9;
  localparam logic [7:0] MAX_MIN_SEC = 8'h59;

  // Any malformed minute/second field (units > 9 or tens > 5) clamps to 59.
  function automatic logic [7:0] bcd_sat(input logic [7:0] v);
    if (v[7:4] > MAX_TENS || v[3:0] > MAX_UNITS) return MAX_MIN_SEC;
    return v;
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_digit_dn.sv
// Single BCD digit down-counter: parallel load, enable, wrap value and borrow out.
module bcd_digit_dn #(
  parameter logic [3:0] WRAP = 4'd9
) (
  input  logic       clk_100M,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       en,
  output logic [3:0] q,
  output logic       zero,
  output logic       borrow
);

  assign zero   = (q == 4'd0);
  assign borrow = en && zero;

  always_ff @(posedge clk_100M) begin
    if (rst)       q <= 4'd0;
    else if (load) q <= load_val;
    else if (en)   q <= zero ? WRAP : q - 4'd1;
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer: clk_1s edge detect, control FSM, digit cascade, optional alarm.
// Build option: define TIMER_ALARM_EN to build the ALARM_SEC-tick alarm counter.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int ALARM_SEC = 5
) (
  input  logic       clk_100M,
  input  logic       rst,
  input  logic       clk_1s,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [7:0] set_min,
  input  logic [7:0] set_sec,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int NUM_DIG = 4;

  if (ALARM_SEC < 1 || ALARM_SEC > 15) begin : g_bad_alarm_sec
    $error("countdown_timer: ALARM_SEC must be 1..15");
  end

  state_t state, state_nxt;
  logic   clk_1s_d, tick;
  logic   load_ok, dec, cnt_zero, cnt_one, done_set;

  logic [NUM_DIG-1:0][3:0] dig, ld_val;
  logic [NUM_DIG-1:0]      dig_zero, dig_borrow;
  logic [NUM_DIG:0]        en;

  // clk_1s is data sampled in this domain; its rising edge is the 1 Hz tick.
  always_ff @(posedge clk_100M) begin
    if (rst) clk_1s_d <= 1'b0;
    else     clk_1s_d <= clk_1s;
  end
  assign tick = clk_1s && !clk_1s_d;

  assign load_ok  = load && (state != ST_RUN);
  assign cnt_zero = &dig_zero;
  assign cnt_one  = &dig_zero[3:1] && (dig[0] == 4'd1);
  assign dec      = (state == ST_RUN) && tick && !pause && !cnt_zero;
  assign done_set = dec && cnt_one;

  // Digit order: [0] sec units, [1] sec tens, [2] min units, [3] min tens.
  assign ld_val = {bcd_sat(set_min), bcd_sat(set_sec)};
  assign en[0]  = dec;

  for (genvar i = 0; i < NUM_DIG; i++) begin : g_dig
    bcd_digit_dn #(
      .WRAP((i % 2) ? MAX_TENS : MAX_UNITS)
    ) u_dig (
      .clk_100M (clk_100M),
      .rst      (rst),
      .load     (load_ok),
      .load_val (ld_val[i]),
      .en       (en[i]),
      .q        (dig[i]),
      .zero     (dig_zero[i]),
      .borrow   (dig_borrow[i])
    );
    assign en[i+1] = dig_borrow[i];
  end

  assign sec_bcd = {dig[1], dig[0]};
  assign min_bcd = {dig[3], dig[2]};

  always_ff @(posedge clk_100M) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Priority: load > pause > start; load is not accepted while running.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_PAUSE: begin
        if (load)                       state_nxt = ST_IDLE;
        else if (pause)                 state_nxt = state;
        else if (start && !cnt_zero)    state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (pause)         state_nxt = ST_PAUSE;
        else if (done_set) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (load) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign running = (state == ST_RUN);

  always_ff @(posedge clk_100M) begin
    if (rst) done <= 1'b0;
    else     done <= done_set;
  end

  // A borrow out of the minute-tens digit would mean wrapping below 00:00.
  always_ff @(posedge clk_100M) begin
    if (!rst) assert (!en[NUM_DIG]);
  end

`ifdef TIMER_ALARM_EN
  logic [3:0] alarm_cnt;
  logic       alarm_q;

  always_ff @(posedge clk_100M) begin
    if (rst || load_ok) begin
      alarm_q   <= 1'b0;
      alarm_cnt <= 4'd0;
    end else if (done_set) begin
      alarm_q   <= 1'b1;
      alarm_cnt <= 4'(ALARM_SEC);
    end else if (alarm_q && tick) begin
      if (alarm_cnt == 4'd1) begin
        alarm_q   <= 1'b0;
        alarm_cnt <= 4'd0;
      end else begin
        alarm_cnt <= alarm_cnt - 4'd1;
      end
    end
  end
  assign alarm = alarm_q;
`else
  assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: vector table plus multi-cycle corner sequences.
module tb_countdown_timer;

`ifdef TIMER_ALARM_EN
  localparam bit AEN = 1'b1;
`else
  localparam bit AEN = 1'b0;
`endif

  logic       clk_100M = 1'b0;
  logic       rst = 1'b1, clk_1s = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [7:0] set_min = 8'h00, set_sec = 8'h00;
  logic [7:0] min_bcd, sec_bcd;
  logic       running, done, alarm;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk_100M = ~clk_100M;

  countdown_timer #(.ALARM_SEC(5)) dut (
    .clk_100M (clk_100M),
    .rst      (rst),
    .clk_1s   (clk_1s),
    .load     (load),
    .start    (start),
    .pause    (pause),
    .set_min  (set_min),
    .set_sec  (set_sec),
    .min_bcd  (min_bcd),
    .sec_bcd  (sec_bcd),
    .running  (running),
    .done     (done),
    .alarm    (alarm)
  );

  typedef struct packed {
    logic       rst, c1s, ld, st, ps;
    logic [7:0] smin, ssec, emin, esec;
    logic       erun, edone, ealm;
  } vec_t;

  vec_t tv[37];

  function automatic vec_t v(logic r, logic c, logic l, logic s, logic p,
                             logic [7:0] smin, logic [7:0] ssec,
                             logic [7:0] emin, logic [7:0] esec,
                             logic er, logic ed, logic ea);
    vec_t t;
    t = '{r, c, l, s, p, smin, ssec, emin, esec, er, ed, ea};
    return t;
  endfunction

  function automatic logic [15:0] to_bcd(int s);
    int m, x;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(logic c, logic l, logic s, logic p, logic [7:0] smin, logic [7:0] ssec);
    @(negedge clk_100M);
    rst = 1'b0; clk_1s = c; load = l; start = s; pause = p;
    set_min = smin; set_sec = ssec;
    @(posedge clk_100M);
    #1;
  endtask

  task automatic chk_cnt(string name, int secs, logic er);
    chk({name, ".count"}, {min_bcd, sec_bcd}, to_bcd(secs));
    chk({name, ".running"}, running, er);
  endtask

  initial begin
    int ndone;
    //         rst c1s ld st ps smin   ssec   emin   esec   run dn alm
    tv[0]  = v(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tv[1]  = v(0, 0, 1, 0, 0, 8'h00, 8'h03, 8'h00, 8'h03, 0, 0, 0);
    tv[2]  = v(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h03, 1, 0, 0);
    tv[3]  = v(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h02, 1, 0, 0);
    tv[4]  = v(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h02, 1, 0, 0);
    tv[5]  = v(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h02, 1, 0, 0);
    tv[6]  = v(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 0);
    tv[7]  = v(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h01, 1, 0, 0);
    tv[8]  = v(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1, 1);
    tv[9]  = v(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1);
    tv[10] = v(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1);
    tv[11] = v(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1);
    tv[12] = v(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 1);
    tv[13] = v(0, 0, 1, 0, 0, 8'h3C, 8'h7A, 8'h59, 8'h59, 0, 0, 0);
    tv[14] = v(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h59, 8'h59, 1, 0, 0);
    tv[15] = v(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h59, 8'h58, 1, 0, 0);
    tv[16] = v(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h59, 8'h58, 0, 0, 0);
    tv[17] = v(0, 1, 0, 1, 1, 8'h00, 8'h00, 8'h59, 8'h58, 0, 0, 0);
    tv[18] = v(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h59, 8'h58, 1, 0, 0);
    tv[19] = v(0, 1, 1, 0, 0, 8'h00, 8'h00, 8'h59, 8'h57, 1, 0, 0);
    tv[20] = v(0, 0, 1, 0, 1, 8'h00, 8'h00, 8'h59, 8'h57, 0, 0, 0);
    tv[21] = v(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tv[22] = v(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tv[23] = v(0, 0, 1, 0, 0, 8'h01, 8'h00, 8'h01, 8'h00, 0, 0, 0);
    tv[24] = v(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h01, 8'h00, 1, 0, 0);
    tv[25] = v(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h59, 1, 0, 0);
    tv[26] = v(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h59, 1, 0, 0);
    tv[27] = v(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tv[28] = v(0, 0, 1, 0, 0, 8'h12, 8'h2F, 8'h12, 8'h59, 0, 0, 0);
    tv[29] = v(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h12, 8'h59, 1, 0, 0);
    tv[30] = v(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h12, 8'h58, 1, 0, 0);
    tv[31] = v(0, 1, 0, 0, 0, 8'h00, 8'h00, 8'h12, 8'h58, 1, 0, 0);
    tv[32] = v(1, 1, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tv[33] = v(0, 0, 1, 0, 0, 8'h00, 8'h02, 8'h00, 8'h02, 0, 0, 0);
    tv[34] = v(0, 0, 0, 1, 0, 8'h00, 8'h00, 8'h00, 8'h02, 1, 0, 0);
    tv[35] = v(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    tv[36] = v(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);

    for (int i = 0; i < 37; i++) begin
      @(negedge clk_100M);
      rst = tv[i].rst; clk_1s = tv[i].c1s; load = tv[i].ld;
      start = tv[i].st; pause = tv[i].ps;
      set_min = tv[i].smin; set_sec = tv[i].ssec;
      @(posedge clk_100M);
      #1;
      chk($sformatf("vec%0d.min", i), min_bcd, tv[i].emin);
      chk($sformatf("vec%0d.sec", i), sec_bcd, tv[i].esec);
      chk($sformatf("vec%0d.running", i), running, tv[i].erun);
      chk($sformatf("vec%0d.done", i), done, tv[i].edone);
      chk($sformatf("vec%0d.alarm", i), alarm, AEN & tv[i].ealm);
    end

    // 01:05 all the way down: exactly one done pulse, running drops with it.
    cyc(0, 1, 0, 0, 8'h01, 8'h05);
    cyc(0, 0, 1, 0, 8'h00, 8'h00);
    ndone = 0;
    for (int s = 64; s >= 0; s--) begin
      cyc(1, 0, 0, 0, 8'h00, 8'h00);
      chk_cnt($sformatf("down.t%0d", s), s, s != 0);
      if (done) ndone++;
      chk("down.done_at_zero", done, s == 0);
      cyc(0, 0, 0, 0, 8'h00, 8'h00);
      if (done) ndone++;
    end
    chk("down.done_pulses", ndone, 1);

    // Alarm lasts exactly 5 ticks after DONE.
    for (int k = 1; k <= 5; k++) begin
      cyc(1, 0, 0, 0, 8'h00, 8'h00);
      chk($sformatf("alarm.tick%0d", k), alarm, AEN && (k < 5));
      cyc(0, 0, 0, 0, 8'h00, 8'h00);
    end

    // 00:10: 3 ticks, pause across 5 ticks, resume for 7 ticks.
    cyc(0, 1, 0, 0, 8'h00, 8'h10);
    cyc(0, 0, 1, 0, 8'h00, 8'h00);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0, 0, 0, 8'h00, 8'h00);
      cyc(0, 0, 0, 0, 8'h00, 8'h00);
    end
    chk_cnt("pz.before", 7, 1);
    cyc(0, 0, 0, 1, 8'h00, 8'h00);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0, 0, 8'h00, 8'h00);
      cyc(0, 0, 0, 0, 8'h00, 8'h00);
    end
    chk_cnt("pz.held", 7, 0);
    cyc(0, 0, 1, 0, 8'h00, 8'h00);
    for (int k = 0; k < 7; k++) begin
      cyc(1, 0, 0, 0, 8'h00, 8'h00);
      if (k == 6) chk("pz.done", done, 1);
      cyc(0, 0, 0, 0, 8'h00, 8'h00);
    end
    chk_cnt("pz.end", 0, 0);

    // Load two ticks into the alarm clears it on the next cycle.
    for (int k = 0; k < 2; k++) begin
      cyc(1, 0, 0, 0, 8'h00, 8'h00);
      cyc(0, 0, 0, 0, 8'h00, 8'h00);
    end
    chk("alarm.mid", alarm, AEN);
    cyc(0, 1, 0, 0, 8'h00, 8'h30);
    chk("alarm.load_clr", alarm, 0);
    chk_cnt("ld30", 30, 0);

    // Pause and tick together at 00:30; then load+start together.
    cyc(0, 0, 1, 0, 8'h00, 8'h00);
    cyc(1, 0, 0, 1, 8'h00, 8'h00);
    chk_cnt("pz_tick", 30, 0);
    cyc(0, 1, 1, 0, 8'h00, 8'h20);
    chk_cnt("ld_st", 20, 0);

    // clk_1s held high for many cycles gives one tick only.
    cyc(0, 0, 1, 0, 8'h00, 8'h00);
    for (int k = 0; k < 20; k++) cyc(1, 0, 0, 0, 8'h00, 8'h00);
    chk_cnt("hold_hi", 19, 1);
    cyc(0, 0, 0, 0, 8'h00, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter ALARM_SEC, default 5, alarm duration in seconds (1..15).
REQ-002 clk_100M  input  1  system clock, 100 MHz.
REQ-003 rst  input  1  reset, synchronous and active-high, sampled on the rising edge of clk_100M.
REQ-004 clk_1s  input  1  divided clock from the upstream divider, registered in the clk_100M domain; treated as data, never as a clock.
REQ-005 load  input  1  latch set_min/set_sec as the new count.
REQ-006 start  input  1  begin or resume counting.
REQ-007 pause  input  1  suspend counting.
REQ-008 set_min  input  8  preset minutes, packed BCD (tens[7:4], units[3:0]).
REQ-009 set_sec  input  8  preset seconds, packed BCD.
REQ-010 min_bcd  output  8  current minutes, packed BCD, registered.
REQ-011 sec_bcd  output  8  current seconds, packed BCD, registered.
REQ-012 running  output  1  high while state is RUN.
REQ-013 done  output  1  one-cycle pulse on the edge the count reaches 00:00.
REQ-014 alarm  output  1  level, high while the alarm is sounding.

Function
REQ-015 tick SHALL be clk_1s AND NOT clk_1s_d, where clk_1s_d is clk_1s delayed one clk_100M cycle; this gives one tick per clk_1s rising edge (1 Hz).
REQ-016 FSM states: IDLE, RUN, PAUSE, DONE.
REQ-017 Load SHALL be accepted in IDLE, PAUSE and DONE and ignored in RUN; an accepted load moves to IDLE.
REQ-018 Load saturation: a BCD field with units >9 or tens >5 SHALL be stored as 59 for that field.
REQ-019 start in IDLE or PAUSE SHALL enter RUN only if count != 00:00; otherwise it is ignored.
REQ-020 start in DONE SHALL be ignored.
REQ-021 In RUN, each tick SHALL decrement the count by one second, with BCD borrow (sec x0 -> (x-1)9, sec 00 -> 59 with min-1); registers update on the edge where tick is high.
REQ-022 When a RUN decrement produces 00:00, the FSM SHALL enter DONE on that same edge, and done SHALL be high for exactly the following cycle.
REQ-023 pause in RUN SHALL move to PAUSE and hold the count.
REQ-024 Precedence on coincident inputs: load > pause > start; pause with tick in RUN SHALL suppress the decrement.
REQ-025 The count SHALL never wrap below 00:00 and never exceed 59:59.

Reset
REQ-026 On rst: state IDLE, min_bcd=00, sec_bcd=00, clk_1s_d=0, running=0, done=0, alarm=0, alarm counter=0.
REQ-027 rst mid-count SHALL discard the count; no done pulse is generated.

Configuration
REQ-028 TIMER_ALARM_EN defined: on entering DONE, alarm SHALL rise and stay high for ALARM_SEC ticks, then fall; an accepted load or rst clears it immediately.
REQ-029 TIMER_ALARM_EN undefined: alarm is tied to 0 and the alarm counter is not built; all other behaviour is unchanged.

Structure
REQ-030 Shared package/header timer_pkg: FSM state encodings, BCD constants (MAX_TENS=5, MAX_UNITS=9, MAX_MIN_SEC=8'h59), saturation helper.
REQ-031 One sub-module, bcd_digit_dn: a single BCD digit down-counter with enable, configurable wrap value and borrow out; four instances cascade sec-units -> sec-tens -> min-units -> min-tens.
REQ-032 Top level holds the edge detector, FSM and alarm counter.

Verification
REQ-033 load 01:05, start, 65 ticks -> 01:04 ... 01:00, 00:59 ... 00:00; done pulses once for 1 cycle; running falls in the same cycle.
REQ-034 load 00:10, start, 3 ticks, pause, 5 ticks, start, 7 ticks -> holds 00:07 while paused, reaches 00:00 / DONE.
REQ-035 Apply pause and tick in the same cycle at 00:30 -> count stays 00:30, state PAUSE; load and start in the same cycle -> IDLE with the new value.
REQ-036 load set_sec=8'h7A, set_min=8'h3C -> 59:59; load 00:00 then start -> stays IDLE, running=0.
REQ-037 rst asserted in RUN at 00:02 -> next cycle 00:00, IDLE, done=0, alarm=0; clk_1s held high for many cycles -> only one tick.
REQ-038 TIMER_ALARM_EN, ALARM_SEC=5: reach DONE -> alarm high for exactly 5 ticks; load after 2 ticks -> alarm low the next cycle.
